// File: rtl/fc_pkg.sv
`default_nettype none
// fc_pkg: shared sizes, weight-row type and controller state encoding for the FC weight buffer.
// Rev 1.0
package fc_pkg;

   localparam int LANES = 128;
   localparam int DEPTH = 128;
   localparam int PTR_W = $clog2(DEPTH);

   typedef logic [LANES-1:0][7:0] weight_row_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_READ = 2'd2,
      ST_DONE = 2'd3
   } fc_state_e;

endpackage

`default_nettype wire

// File: rtl/fc_row_counter.sv
`default_nettype none
// fc_row_counter: up-counter that returns to zero after reaching limit, with a wrap pulse.
// Rev 1.0
module fc_row_counter
#(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         wrap
);
   import fc_pkg::*;

   assign wrap = en & (count == limit);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/fc_weight_buf.sv
`default_nettype none
// fc_weight_buf: weight row storage with a registered, one-cycle read port.
// Rev 1.0
module fc_weight_buf
#(
   parameter int  LANES = fc_pkg::LANES,
   parameter int  DEPTH = fc_pkg::DEPTH,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rst_all_n,
   input  logic               wren,
   input  logic [PW-1:0]      wrptr,
   input  logic [LANES*8-1:0] wdata,
   input  logic               rden,
   input  logic [PW-1:0]      rdptr,
   output logic [LANES*8-1:0] rdata
);
   import fc_pkg::*;

   logic [LANES*8-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_all_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wren) begin
         mem[wrptr] <= wdata;
      end
   end

   // rst_n only clears the output register; stored rows survive between jobs
   always_ff @(posedge clk) begin
      if (!rst_n || !rst_all_n) begin
         rdata <= '0;
      end else if (rden) begin
         rdata <= mem[rdptr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/fc_weight_buf_ctrl.sv
`default_nettype none
// fc_weight_buf_ctrl: loads weight rows into the buffer, then streams them out for N passes.
// Rev 1.0
module fc_weight_buf_ctrl
#(
   parameter int  LANES = fc_pkg::LANES,
   parameter int  DEPTH = fc_pkg::DEPTH,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [7:0]         rows_i,
   input  logic [3:0]         passes_i,
   input  logic               abort_i,
   input  logic               wvalid_i,
   output logic               wready_o,
   input  logic [LANES*8-1:0] weight_i,
   input  logic               rd_en_i,
   output logic               buf_wren_o,
   output logic [PW-1:0]      buf_wrptr_o,
   output logic [LANES*8-1:0] buf_weight_o,
   output logic               buf_rden_o,
   output logic [PW-1:0]      buf_rdptr_o,
   output logic               buf_rst_n_o,
   output logic               buf_rst_all_o,
   output logic               row_valid_o,
   output logic [PW-1:0]      row_idx_o,
   output logic               last_o,
   output logic               busy_o,
   output logic               done_o
);
   import fc_pkg::*;

   localparam logic [7:0] DEPTH_ROWS = 8'(DEPTH);

   fc_state_e     state;
   logic [PW-1:0] rows_last;
   logic [3:0]    passes_last;
   logic [7:0]    rows_sat;
   logic          in_idle, in_load, in_read, in_done;
   logic          wr_fire, rd_fire, cnt_clr;
   logic [PW-1:0] wr_count, rd_count;
   logic [3:0]    pass_count;
   logic          wr_wrap, rd_wrap, pass_wrap, final_rd;
   logic          row_valid, last, done;
   logic [PW-1:0] row_idx;

   assign in_idle  = (state == ST_IDLE);
   assign in_load  = (state == ST_LOAD);
   assign in_read  = (state == ST_READ);
   assign in_done  = (state == ST_DONE);
   assign rows_sat = (rows_i > DEPTH_ROWS) ? DEPTH_ROWS : rows_i;
   assign wr_fire  = in_load & wvalid_i & ~abort_i;
   assign rd_fire  = in_read & rd_en_i & ~abort_i;
   assign cnt_clr  = abort_i | in_idle | in_done;
   assign final_rd = rd_wrap & (pass_count == passes_last);

   fc_row_counter #(.W(PW)) u_wr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (wr_fire),
      .limit (rows_last),
      .count (wr_count),
      .wrap  (wr_wrap)
   );

   fc_row_counter #(.W(PW)) u_rd_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (rd_fire),
      .limit (rows_last),
      .count (rd_count),
      .wrap  (rd_wrap)
   );

   fc_row_counter #(.W(4)) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (rd_wrap),
      .limit (passes_last),
      .count (pass_count),
      .wrap  (pass_wrap)
   );

   // config is held as last-index values so the counters compare directly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         rows_last   <= '0;
         passes_last <= '0;
         row_valid   <= 1'b0;
         row_idx     <= '0;
         last        <= 1'b0;
         done        <= 1'b0;
      end else if (abort_i) begin
         state       <= ST_IDLE;
         rows_last   <= '0;
         passes_last <= '0;
         row_valid   <= 1'b0;
         last        <= 1'b0;
         done        <= 1'b0;
      end else begin
         row_valid <= rd_fire;
         last      <= final_rd;
         done      <= in_done;
         if (rd_fire) begin
            row_idx <= rd_count;
         end
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  rows_last   <= PW'(rows_sat - 8'd1);
                  passes_last <= passes_i - 4'd1;
                  state       <= (rows_sat == 8'd0 || passes_i == 4'd0) ? ST_DONE : ST_LOAD;
               end
            end
            ST_LOAD: if (wr_wrap)   state <= ST_READ;
            ST_READ: if (pass_wrap) state <= ST_DONE;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign wready_o      = in_load;
   assign buf_wren_o    = wr_fire;
   assign buf_wrptr_o   = wr_count;
   assign buf_weight_o  = weight_i;
   assign buf_rden_o    = rd_fire;
   assign buf_rdptr_o   = rd_count;
   assign buf_rst_n_o   = in_load | in_read;
   assign buf_rst_all_o = rst_n & ~abort_i;
   assign row_valid_o   = row_valid;
   assign row_idx_o     = row_idx;
   assign last_o        = last;
   assign busy_o        = ~in_idle;
   assign done_o        = done;

endmodule

`default_nettype wire

// File: tb/tb_fc_weight_buf_ctrl.sv
`default_nettype none
// tb_fc_weight_buf_ctrl: directed bench for the controller driving an fc_weight_buf instance.
// Rev 1.0
module tb_fc_weight_buf_ctrl;
   import fc_pkg::*;

   localparam int LW = LANES * 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_i = 1'b0;
   logic [7:0]       rows_i = '0;
   logic [3:0]       passes_i = '0;
   logic             abort_i = 1'b0;
   logic             wvalid_i = 1'b0;
   logic             wready_o;
   logic [LW-1:0]    weight_i = '0;
   logic             rd_en_i = 1'b0;
   logic             buf_wren_o, buf_rden_o, buf_rst_n_o, buf_rst_all_o;
   logic [PTR_W-1:0] buf_wrptr_o, buf_rdptr_o, row_idx_o;
   logic [LW-1:0]    buf_weight_o, buf_rdata;
   logic             row_valid_o, last_o, busy_o, done_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fc_weight_buf_ctrl #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .rows_i(rows_i), .passes_i(passes_i),
      .abort_i(abort_i), .wvalid_i(wvalid_i), .wready_o(wready_o), .weight_i(weight_i),
      .rd_en_i(rd_en_i), .buf_wren_o(buf_wren_o), .buf_wrptr_o(buf_wrptr_o),
      .buf_weight_o(buf_weight_o), .buf_rden_o(buf_rden_o), .buf_rdptr_o(buf_rdptr_o),
      .buf_rst_n_o(buf_rst_n_o), .buf_rst_all_o(buf_rst_all_o), .row_valid_o(row_valid_o),
      .row_idx_o(row_idx_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
   );

   fc_weight_buf #(.LANES(LANES), .DEPTH(DEPTH)) u_buf (
      .clk(clk), .rst_n(buf_rst_n_o), .rst_all_n(buf_rst_all_o), .wren(buf_wren_o),
      .wrptr(buf_wrptr_o), .wdata(buf_weight_o), .rden(buf_rden_o), .rdptr(buf_rdptr_o),
      .rdata(buf_rdata)
   );

   function automatic logic [LW-1:0] row_pat(input int r);
      row_pat = {LANES{8'(r + 1)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int rows, input int passes);
      start_i  = 1'b1;
      rows_i   = 8'(rows);
      passes_i = 4'(passes);
      tick();
      start_i  = 1'b0;
   endtask

   // drives row r with byte value r+1 in every lane until n beats are accepted
   task automatic load_rows(input int n, input bit gaps, output int n_wren, output int err);
      int acc;
      int cyc;
      acc = 0; cyc = 0; n_wren = 0; err = 0;
      while (acc < n && cyc < 4 * n + 20) begin
         wvalid_i = gaps ? ((cyc % 3) != 1) : 1'b1;
         weight_i = row_pat(acc);
         @(negedge clk);
         if (wready_o !== 1'b1 || buf_wren_o !== wvalid_i) err++;
         if (buf_wren_o === 1'b1) begin
            if (buf_wrptr_o !== PTR_W'(acc) || buf_weight_o !== row_pat(acc)) err++;
            n_wren++;
            acc++;
         end
         tick();
         cyc++;
      end
      wvalid_i = 1'b0;
   endtask

   // read phase: the bench models which reads are issued and when rows must appear
   task automatic run_read(input int rows, input int total, input bit toggle, input int budget,
                           output int n_valid, output int seq_err, output int n_last,
                           output int last_k, output int done_gap);
      int  n_iss;
      int  cyc;
      int  last_cyc;
      int  done_cyc;
      bit  exp_rden;
      bit  prev_exp;
      n_iss = 0; cyc = 0; last_cyc = -1; done_cyc = -1; prev_exp = 1'b0;
      n_valid = 0; seq_err = 0; n_last = 0; last_k = -1; done_gap = -1;
      while (done_cyc < 0 && cyc < budget) begin
         rd_en_i = toggle ? ((cyc % 2) == 0) : 1'b1;
         exp_rden = (n_iss < total) ? rd_en_i : 1'b0;
         @(negedge clk);
         if (buf_rden_o !== exp_rden) seq_err++;
         if (exp_rden) begin
            if (buf_rdptr_o !== PTR_W'(n_iss % rows)) seq_err++;
            n_iss++;
         end
         if (row_valid_o !== prev_exp) seq_err++;
         if (row_valid_o === 1'b1) begin
            if (row_idx_o !== PTR_W'(n_valid % rows) || buf_rdata !== row_pat(n_valid % rows))
               seq_err++;
            if (last_o === 1'b1) begin
               n_last++;
               last_k   = n_valid;
               last_cyc = cyc;
            end
            n_valid++;
         end else if (last_o !== 1'b0) begin
            seq_err++;
         end
         if (done_o === 1'b1) done_cyc = cyc;
         prev_exp = exp_rden;
         tick();
         cyc++;
      end
      rd_en_i = 1'b0;
      if (done_cyc >= 0 && last_cyc >= 0) done_gap = done_cyc - last_cyc;
   endtask

   task automatic test_reset();
      wvalid_i = 1'b1; rd_en_i = 1'b1; start_i = 1'b1; rows_i = 8'd5; passes_i = 4'd1;
      tick(); tick();
      @(negedge clk);
      n_checks++; if ({wready_o, buf_wren_o, buf_rden_o, row_valid_o, last_o, busy_o, done_o} !== 7'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000000",
            {wready_o, buf_wren_o, buf_rden_o, row_valid_o, last_o, busy_o, done_o}); end
      n_checks++; if ({buf_rst_n_o, buf_rst_all_o} !== 2'b00) begin
         n_fail++; $display("FAIL reset_buf_rst: got %b want 00", {buf_rst_n_o, buf_rst_all_o}); end
      n_checks++; if (buf_wrptr_o !== '0 || buf_rdptr_o !== '0 || row_idx_o !== '0) begin
         n_fail++; $display("FAIL reset_ptrs: got %0d/%0d/%0d want 0/0/0", buf_wrptr_o, buf_rdptr_o, row_idx_o); end
      rst_n = 1'b1; start_i = 1'b0;
      tick();
      @(negedge clk);
      n_checks++; if ({busy_o, buf_rden_o, buf_wren_o, buf_rst_all_o} !== 4'b0001) begin
         n_fail++; $display("FAIL idle_ignores_inputs: got %b want 0001", {busy_o, buf_rden_o, buf_wren_o, buf_rst_all_o}); end
      wvalid_i = 1'b0; rd_en_i = 1'b0;
      tick();
   endtask

   task automatic test_single_pass();
      int nw, err, nv, se, nl, lk, dg;
      do_start(84, 1);
      @(negedge clk);
      n_checks++; if ({busy_o, wready_o, buf_rst_n_o} !== 3'b111) begin
         n_fail++; $display("FAIL load_entry: got %b want 111", {busy_o, wready_o, buf_rst_n_o}); end
      tick();
      load_rows(84, 1'b0, nw, err);
      n_checks++; if (nw != 84 || err != 0) begin
         n_fail++; $display("FAIL sp_load: got %0d writes %0d errors want 84/0", nw, err); end
      @(negedge clk);
      n_checks++; if ({busy_o, wready_o} !== 2'b10) begin
         n_fail++; $display("FAIL sp_read_entry: got %b want 10", {busy_o, wready_o}); end
      tick();
      run_read(84, 84, 1'b0, 300, nv, se, nl, lk, dg);
      n_checks++; if (nv != 84 || se != 0) begin
         n_fail++; $display("FAIL sp_rows: got %0d rows %0d errors want 84/0", nv, se); end
      n_checks++; if (nl != 1 || lk != 83) begin
         n_fail++; $display("FAIL sp_last: got %0d lasts at %0d want 1 at 83", nl, lk); end
      n_checks++; if (dg != 1) begin
         n_fail++; $display("FAIL sp_done_gap: got %0d want 1", dg); end
      @(negedge clk);
      n_checks++; if ({done_o, busy_o, buf_rst_n_o} !== 3'b000) begin
         n_fail++; $display("FAIL sp_after_done: got %b want 000", {done_o, busy_o, buf_rst_n_o}); end
      tick();
   endtask

   task automatic test_multi_pass();
      int nw, err, nv, se, nl, lk, dg;
      do_start(4, 3);
      load_rows(4, 1'b0, nw, err);
      run_read(4, 12, 1'b0, 100, nv, se, nl, lk, dg);
      n_checks++; if (nv != 12 || se != 0) begin
         n_fail++; $display("FAIL mp_rows: got %0d rows %0d errors want 12/0", nv, se); end
      n_checks++; if (nl != 1 || lk != 11) begin
         n_fail++; $display("FAIL mp_last: got %0d lasts at %0d want 1 at 11", nl, lk); end
      n_checks++; if (dg != 1) begin
         n_fail++; $display("FAIL mp_done_gap: got %0d want 1", dg); end
   endtask

   task automatic test_rd_toggle();
      int nw, err, nv, se, nl, lk, dg;
      do_start(5, 2);
      load_rows(5, 1'b0, nw, err);
      run_read(5, 10, 1'b1, 100, nv, se, nl, lk, dg);
      n_checks++; if (nv != 10 || se != 0 || lk != 9) begin
         n_fail++; $display("FAIL toggle_rows: got %0d rows %0d errors last %0d want 10/0/9", nv, se, lk); end
   endtask

   task automatic test_load_gaps();
      int nw, err, nv, se, nl, lk, dg;
      do_start(8, 1);
      load_rows(8, 1'b1, nw, err);
      n_checks++; if (nw != 8 || err != 0) begin
         n_fail++; $display("FAIL gap_load: got %0d writes %0d errors want 8/0", nw, err); end
      wvalid_i = 1'b1;
      weight_i = '1;
      @(negedge clk);
      n_checks++; if ({buf_wren_o, wready_o, buf_rden_o} !== 3'b000) begin
         n_fail++; $display("FAIL wvalid_in_read: got %b want 000", {buf_wren_o, wready_o, buf_rden_o}); end
      tick();
      wvalid_i = 1'b0;
      run_read(8, 8, 1'b0, 60, nv, se, nl, lk, dg);
      n_checks++; if (nv != 8 || se != 0 || dg != 1) begin
         n_fail++; $display("FAIL gap_read: got %0d rows %0d errors gap %0d want 8/0/1", nv, se, dg); end
   endtask

   task automatic test_abort();
      int nw, err, nv, se, nl, lk, dg, n_done;
      do_start(84, 1);
      load_rows(84, 1'b0, nw, err);
      rd_en_i = 1'b1;
      repeat (10) tick();
      abort_i = 1'b1;
      @(negedge clk);
      n_checks++; if (buf_rst_all_o !== 1'b0) begin
         n_fail++; $display("FAIL abort_rst_all: got %b want 0", buf_rst_all_o); end
      n_checks++; if (row_valid_o !== 1'b1 || row_idx_o !== PTR_W'(9)) begin
         n_fail++; $display("FAIL abort_cycle_row: got valid %b idx %0d want 1/9", row_valid_o, row_idx_o); end
      tick();
      abort_i = 1'b0;
      @(negedge clk);
      n_checks++; if ({busy_o, row_valid_o, buf_rst_n_o, buf_rden_o} !== 4'b0000) begin
         n_fail++; $display("FAIL abort_idle: got %b want 0000", {busy_o, row_valid_o, buf_rst_n_o, buf_rden_o}); end
      n_done = 0;
      repeat (4) begin
         if (done_o === 1'b1) n_done++;
         tick();
         @(negedge clk);
      end
      n_checks++; if (n_done != 0) begin
         n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", n_done); end
      tick();
      rd_en_i = 1'b0;
      do_start(3, 1);
      @(negedge clk);
      n_checks++; if ({busy_o, wready_o} !== 2'b11) begin
         n_fail++; $display("FAIL restart_accepted: got %b want 11", {busy_o, wready_o}); end
      tick();
      load_rows(3, 1'b0, nw, err);
      run_read(3, 3, 1'b0, 40, nv, se, nl, lk, dg);
      n_checks++; if (nv != 3 || se != 0 || dg != 1) begin
         n_fail++; $display("FAIL restart_read: got %0d rows %0d errors gap %0d want 3/0/1", nv, se, dg); end
   endtask

   task automatic test_abort_start();
      start_i = 1'b1; abort_i = 1'b1; rows_i = 8'd4; passes_i = 4'd1;
      tick();
      start_i = 1'b0; abort_i = 1'b0;
      @(negedge clk);
      n_checks++; if ({busy_o, wready_o} !== 2'b00) begin
         n_fail++; $display("FAIL abort_beats_start: got %b want 00", {busy_o, wready_o}); end
      tick();
   endtask

   task automatic test_zero_rows();
      wvalid_i = 1'b1; rd_en_i = 1'b1;
      do_start(0, 5);
      @(negedge clk);
      n_checks++; if ({busy_o, done_o, wready_o, buf_wren_o, buf_rden_o, buf_rst_n_o} !== 6'b100000) begin
         n_fail++; $display("FAIL zero_done_state: got %b want 100000",
            {busy_o, done_o, wready_o, buf_wren_o, buf_rden_o, buf_rst_n_o}); end
      tick();
      @(negedge clk);
      n_checks++; if ({done_o, busy_o, buf_wren_o, buf_rden_o} !== 4'b1000) begin
         n_fail++; $display("FAIL zero_done_pulse: got %b want 1000", {done_o, busy_o, buf_wren_o, buf_rden_o}); end
      tick();
      @(negedge clk);
      n_checks++; if (done_o !== 1'b0) begin
         n_fail++; $display("FAIL zero_done_width: got %b want 0", done_o); end
      tick();
      do_start(5, 0);
      @(negedge clk);
      n_checks++; if ({busy_o, wready_o, buf_wren_o} !== 3'b100) begin
         n_fail++; $display("FAIL zero_passes_state: got %b want 100", {busy_o, wready_o, buf_wren_o}); end
      tick();
      @(negedge clk);
      n_checks++; if (done_o !== 1'b1) begin
         n_fail++; $display("FAIL zero_passes_done: got %b want 1", done_o); end
      wvalid_i = 1'b0; rd_en_i = 1'b0;
      tick();
   endtask

   task automatic test_saturate();
      int nw, err, nv, se, nl, lk, dg;
      do_start(200, 1);
      load_rows(128, 1'b0, nw, err);
      n_checks++; if (nw != 128 || err != 0) begin
         n_fail++; $display("FAIL sat_load: got %0d writes %0d errors want 128/0", nw, err); end
      wvalid_i = 1'b1;
      @(negedge clk);
      n_checks++; if ({wready_o, buf_wren_o} !== 2'b00) begin
         n_fail++; $display("FAIL sat_rows_loaded: got %b want 00", {wready_o, buf_wren_o}); end
      tick();
      wvalid_i = 1'b0;
      run_read(128, 128, 1'b0, 300, nv, se, nl, lk, dg);
      n_checks++; if (nv != 128 || se != 0 || lk != 127) begin
         n_fail++; $display("FAIL sat_read: got %0d rows %0d errors last %0d want 128/0/127", nv, se, lk); end
   endtask

   task automatic test_reset_mid_load();
      do_start(8, 1);
      wvalid_i = 1'b1;
      weight_i = row_pat(40);
      repeat (3) tick();
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++; if (buf_rst_all_o !== 1'b0) begin
         n_fail++; $display("FAIL midreset_rst_all: got %b want 0", buf_rst_all_o); end
      tick();
      rst_n = 1'b1;
      wvalid_i = 1'b0;
      @(negedge clk);
      n_checks++; if ({busy_o, wready_o, buf_rst_n_o} !== 3'b000) begin
         n_fail++; $display("FAIL midreset_idle: got %b want 000", {busy_o, wready_o, buf_rst_n_o}); end
      n_checks++; if (u_buf.mem[1] !== '0) begin
         n_fail++; $display("FAIL midreset_buf_clear: got %0h want 0", u_buf.mem[1][7:0]); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_rd_toggle();
      test_load_gaps();
      test_abort();
      test_abort_start();
      test_zero_rows();
      test_saturate();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
